// File: rtl/clm_mod_p_out_pkg.sv
// Shared types for the CLM AES output back-end (clm_mod_p_out).
// Polynomial vectors are held MSB-first: numeric bit k of a state_t is the
// coefficient of x^k, so bit (7+D) is the leading coefficient.
package clm_mod_p_out_pkg;

    localparam int D             = 7;        // redundancy degree
    localparam int ELEM_W        = 8 + D;    // width of one redundant element
    localparam int NBYTES        = 16;       // state bytes per block
    localparam int MP_STAGE_BITS = 2;

    // One redundant element of the state.
    typedef logic [ELEM_W-1:0] state_t;

    // Element [i][j] maps to ciphertext byte 4*i+j.
    typedef state_t [3:0][3:0] state_vec_t;

    // Base polynomial; numeric bit 8 is the coefficient of x^8.
    typedef logic [8:0] base_poly_t;

    // Basis-change matrix: row i, column j is the array index pair [i][j].
    typedef logic [7:0][7:0] mm_matrix_t;

    typedef logic [3:0] byte_idx_t;

    typedef enum logic [MP_STAGE_BITS-1:0] {
        MP_IDLE   = 2'd0,
        MP_REDUCE = 2'd1,
        MP_HOLD   = 2'd2
    } mp_stages_t;

endpackage

// File: rtl/clm_mod_p_out_poly_reduce.sv
// clm_poly_reduce: combinational reduction of one redundant element modulo
// the base polynomial P, followed by the Linv basis change back to AES.
// Written standalone so an input-side lifting stage can reuse it.
module clm_poly_reduce
    import clm_mod_p_out_pkg::*;
(
    input  state_t     x,
    input  base_poly_t P,
    input  mm_matrix_t Linv,
    output logic [7:0] aes_byte
);

    state_t rem;

    // Long division by P, leading coefficient first, D fixed steps.
    // A step whose leading bit is set always XORs P in, even if P's own
    // leading coefficient is 0; no special case for a degenerate P.
    always_comb begin
        rem = x;
        for (int s = 0; s < D; s++) begin
            if (rem[ELEM_W-1-s]) begin
                rem = rem ^ (ELEM_W'(P) << (D - 1 - s));
            end
        end
    end

    // GF(2) matrix-vector product. Row/column index 0 is the MSB, so column j
    // picks remainder bit 7-j and row i drives output bit 7-i.
    always_comb begin
        aes_byte = '0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                aes_byte[7-i] = aes_byte[7-i] ^ (Linv[i][j] & rem[7-j]);
            end
        end
    end

endmodule

// File: rtl/clm_mod_p_out.sv
// clm_mod_p_out: output back-end of the CLM AES core. Latches the final
// redundant state, reduces/maps one byte per cycle through a single
// clm_poly_reduce, and returns the 128-bit ciphertext over valid/ready.
// Optional macro CLM_MOD_P_ZEROIZE_EN: clears latched data and ciphertext on
// the output handshake and forces ciphertext to 0 while out_valid is low.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high; in_ready/out_valid are decoded from the registered stage so
// they never depend combinationally on the partner's signal.
module clm_mod_p_out
    import clm_mod_p_out_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  state_vec_t   state_in,
    input  base_poly_t   P,
    input  mm_matrix_t   Linv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext
);

    mp_stages_t          stage_q, stage_d;
    byte_idx_t           byte_ctr_q, byte_ctr_d;
    state_vec_t          state_q, state_d;
    base_poly_t          p_q, p_d;
    mm_matrix_t          linv_q, linv_d;
    logic [8*NBYTES-1:0] ct_q, ct_d;

    state_t     cur_elem;
    logic [7:0] cur_byte;

    assign cur_elem = state_q[byte_ctr_q[3:2]][byte_ctr_q[1:0]];

    clm_poly_reduce u_reduce (
        .x        (cur_elem),
        .P        (p_q),
        .Linv     (linv_q),
        .aes_byte (cur_byte)
    );

    // Stage sequencing, latching on acceptance and per-byte ciphertext writes.
    always_comb begin
        stage_d    = stage_q;
        byte_ctr_d = byte_ctr_q;
        state_d    = state_q;
        p_d        = p_q;
        linv_d     = linv_q;
        ct_d       = ct_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (stage_q)
            MP_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d    = state_in;
                    p_d        = P;
                    linv_d     = Linv;
                    byte_ctr_d = '0;
                    stage_d    = MP_REDUCE;
                end
            end
            MP_REDUCE: begin
                ct_d[8*byte_ctr_q +: 8] = cur_byte;
                byte_ctr_d              = byte_ctr_q + 4'd1;
                if (byte_ctr_q == byte_idx_t'(NBYTES - 1)) begin
                    stage_d = MP_HOLD;
                end
            end
            MP_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    stage_d = MP_IDLE;
`ifdef CLM_MOD_P_ZEROIZE_EN
                    state_d = '0;
                    p_d     = '0;
                    linv_d  = '0;
                    ct_d    = '0;
`endif
                end
            end
            default: stage_d = MP_IDLE;
        endcase
    end

    // State registers; reset aborts any block in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_q    <= MP_IDLE;
            byte_ctr_q <= '0;
            state_q    <= '0;
            p_q        <= '0;
            linv_q     <= '0;
            ct_q       <= '0;
        end else begin
            stage_q    <= stage_d;
            byte_ctr_q <= byte_ctr_d;
            state_q    <= state_d;
            p_q        <= p_d;
            linv_q     <= linv_d;
            ct_q       <= ct_d;
        end
    end

`ifdef CLM_MOD_P_ZEROIZE_EN
    assign ciphertext = out_valid ? ct_q : '0;
`else
    assign ciphertext = ct_q;
`endif

endmodule

// File: doc/clm_mod_p_out.md
Name: clm_mod_p_out

Overview:
- Output back-end of the CLM AES core. It consumes the final redundant 16-byte state (`state_vec_t`, 15-bit elements, m=8, d=7) after ADD_ROUND_KEY_LAST.
- Each element is reduced modulo the base polynomial P, then mapped back to the AES basis through Linv.
- The result is the 128-bit ciphertext, returned over a valid/ready handshake.
- One byte is processed per cycle, so the reduction logic is instantiated once rather than 16 times.

Parameters:
- D, `` `d `` (7): redundancy degree. Each element has width 8+D.
- NBYTES, 16: number of state bytes processed per block.

Ports:
- `clk` input 1: clock.
- `rst` input 1: reset. Asynchronous, active-low.
- `in_valid` input 1: `state_in`, `P` and `Linv` are valid.
- `in_ready` output 1: block can accept a new state.
- `state_in` input `state_vec_t`: redundant state. Element [i][j] maps to ciphertext byte 4*i+j.
- `P` input `base_poly_t`: base polynomial. P[0] is the coefficient of x^8.
- `Linv` input `mm_matrix_t`: P-basis to AES-basis matrix.
- `out_valid` output 1: ciphertext is valid.
- `out_ready` input 1: consumer accepts the ciphertext.
- `ciphertext` output 128: byte k occupies bits [8k +: 8]; bit 0 is the MSB.

Behaviour:
- Bit conventions:
  - `state_t` bit 0 is the coefficient of x^(7+D).
  - A reduced byte v[0..7] has v[0] = coefficient of x^7.
  - Output bit out[i] = XOR over j of (Linv[i][j] & r[j]). Index 0 is the MSB.
- Reduction: long division by P, highest degree first, for D steps. For step s = 0..D-1, if bit s is set, XOR P into bits [s : s+8]. The remainder is bits [D : D+7].
  - P[0]=0 is not trapped; the division proceeds as written.
- FSM `mp_stages_t`: MP_IDLE, MP_REDUCE, MP_HOLD.
- MP_IDLE:
  - `in_ready`=1.
  - On `in_valid`: latch all of `state_in`, `P` and `Linv` into local registers, clear `byte_ctr`, go to MP_REDUCE.
  - Input changes after acceptance are ignored.
- MP_REDUCE:
  - `in_ready`=0.
  - Each cycle, reduce and map byte `byte_ctr` and write it into the ciphertext register, then increment `byte_ctr` (4 bits).
  - When `byte_ctr`==15, go to MP_HOLD. There is no counter wrap inside a block.
- MP_HOLD:
  - `out_valid`=1; `ciphertext` is stable.
  - When `out_ready`=1, go to MP_IDLE (`out_valid` drops next cycle). `out_ready` low holds the state indefinitely.
- Latency:
  - Acceptance edge at cycle 0.
  - Bytes written at cycles 1..16.
  - `out_valid` high from cycle 17.
  - A new input can be accepted in the cycle after the output handshake.
- Simultaneous events: `in_valid` during MP_REDUCE or MP_HOLD is ignored, because the producer sees `in_ready`=0.
- Reset values: `in_ready`=1, `out_valid`=0, `ciphertext`=0, `byte_ctr`=0, FSM=MP_IDLE, latched registers=0.
- Reset asserted mid-operation aborts immediately; no partial output is flagged valid.

Optional Feature:
- Macro: `CLM_MOD_P_ZEROIZE_EN`.
- Defined:
  - On the output handshake, the latched state, P, Linv and `ciphertext` registers are cleared to 0.
  - `ciphertext` is driven 0 whenever `out_valid`=0, so partial results are never visible.
- Undefined:
  - Registers keep their values after the handshake.
  - `ciphertext` shows bytes as they are written and keeps the last value in MP_IDLE.

Decomposition:
- Add to package `types`:
  - `mp_stages_t` enum, width `` `MP_STAGE_BITS `` = 2.
  - `byte_idx_t` (logic[3:0]).
  - `NBYTES` constant.
- Sub-module `clm_poly_reduce`: purely combinational. Inputs `state_t` x, `base_poly_t` P, `mm_matrix_t` Linv; output 8-bit AES byte. Instantiated once.
  - It can be reused later by an input-side lifting stage.

Test Plan (P = 9'b1_0001_1011, i.e. 0x11B, with Linv = identity unless stated):
- Every element = 15'h0057 -> `ciphertext` = 0x57 repeated 16 times; `out_valid` rises exactly at cycle 17.
- Element 0 = 15'h0100, element 1 = 15'h4000, element 2 = 15'h7FFF, others 0 -> bytes 0x1B, 0x9A, 0x1A, then zeros.
- Linv = bit-reversal (Linv[i][7-i]=1), all elements 15'h0001 -> every byte 0x80.
- `out_ready` held low 5 cycles in MP_HOLD -> `out_valid` and `ciphertext` stable; `in_ready`=0; a concurrent `in_valid` pulse is ignored.
- Back-to-back blocks with `out_ready`=1 -> second block accepted at cycle 18 with correct independent result.
- `rst` low at cycle 8 of MP_REDUCE -> asynchronous return to reset values; a following block produces a correct result.
  - With `CLM_MOD_P_ZEROIZE_EN` defined, `ciphertext` reads 0 while `out_valid`=0.
